// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path: bus layout, saturation
// limits, conversion FSM states and seven-segment codes (active-low form).
package stopwatch_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int MS_W  = 10;

    localparam int MS_LSB  = 0;
    localparam int SEC_LSB = MS_LSB + MS_W;
    localparam int MIN_LSB = SEC_LSB + SEC_W;
    localparam int HR_LSB  = MIN_LSB + MIN_W;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;

    typedef enum logic [2:0] {
        IDLE,
        CONV_HR,
        CONV_MIN,
        CONV_SEC,
        CONV_MS,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 binary to BCD converter. start loads a width-bit value,
// then one bit is shifted per cycle; done flags the cycle of the final shift.
module bin2bcd_serial (
    input  logic        clk_1khz,
    input  logic        reset_in,
    input  logic        start,
    input  logic [9:0]  bin,
    input  logic [3:0]  width,
    output logic        done,
    output logic [11:0] bcd
);

    logic [21:0] sh_q;
    logic [21:0] sh_d;
    logic [3:0]  rem_q;
    logic [11:0] adj;
    logic [9:0]  bin_aligned;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (sh_q[10 + gi*4 +: 4] >= 4'd5) ?
                                    sh_q[10 + gi*4 +: 4] + 4'd3 :
                                    sh_q[10 + gi*4 +: 4];
        end
    endgenerate

    // MSB of the field is moved to bit 9 so every width shifts out the same way
    assign bin_aligned = bin << (4'd10 - width);
    assign sh_d        = {adj[10:0], sh_q[9:0], 1'b0};

    always_ff @(posedge clk_1khz or negedge reset_in) begin
        if (!reset_in) begin
            sh_q  <= '0;
            rem_q <= '0;
        end else if (start) begin
            sh_q  <= {12'd0, bin_aligned};
            rem_q <= width;
        end else if (rem_q != 4'd0) begin
            sh_q  <= sh_d;
            rem_q <= rem_q - 4'd1;
        end
    end

    assign done = (rem_q == 4'd1) && !start;
    assign bcd  = sh_q[21:10];

endmodule

// File: rtl/stopwatch_display.sv
// Snapshot, saturate and BCD-convert the stopwatch time bus, then scan it onto
// an 8-digit seven-segment display. Optional lap freeze: define LAP_HOLD_EN.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV       = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_1khz,
    input  logic        reset_in,
    input  logic [26:0] digit,
    input  logic        lap,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        upd
);

    logic hold;

`ifdef LAP_HOLD_EN
    logic [2:0] lap_sync_q;
    logic       hold_q;

    always_ff @(posedge clk_1khz or negedge reset_in) begin
        if (!reset_in) begin
            lap_sync_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            lap_sync_q <= {lap_sync_q[1:0], lap};
            if (lap_sync_q[1] && !lap_sync_q[2])
                hold_q <= ~hold_q;
        end
    end
    assign hold = hold_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign hold       = 1'b0;
`endif

    logic [HR_W-1:0]  hr_sat;
    logic [MIN_W-1:0] min_sat;
    logic [SEC_W-1:0] sec_sat;
    logic [MS_W-1:0]  ms_sat;
    logic [26:0]      sat;

    assign hr_sat  = (digit[HR_LSB  +: HR_W]  > HR_MAX)  ? HR_MAX  : digit[HR_LSB  +: HR_W];
    assign min_sat = (digit[MIN_LSB +: MIN_W] > MIN_MAX) ? MIN_MAX : digit[MIN_LSB +: MIN_W];
    assign sec_sat = (digit[SEC_LSB +: SEC_W] > SEC_MAX) ? SEC_MAX : digit[SEC_LSB +: SEC_W];
    assign ms_sat  = (digit[MS_LSB  +: MS_W]  > MS_MAX)  ? MS_MAX  : digit[MS_LSB  +: MS_W];
    assign sat     = {hr_sat, min_sat, sec_sat, ms_sat};

    state_t      state_q;
    logic [26:0] snap_q;
    logic        start_q;
    logic [7:0]  bcd_hr_q;
    logic [7:0]  bcd_min_q;
    logic [7:0]  bcd_sec_q;
    logic [31:0] disp_q;
    logic        upd_q;

    logic [9:0]  conv_bin;
    logic [3:0]  conv_w;
    logic        conv_done;
    logic [11:0] conv_bcd;

    always_comb begin
        conv_bin = '0;
        conv_w   = 4'(MS_W);
        case (state_q)
            CONV_HR:  begin conv_bin = 10'(snap_q[HR_LSB  +: HR_W]);  conv_w = 4'(HR_W);  end
            CONV_MIN: begin conv_bin = 10'(snap_q[MIN_LSB +: MIN_W]); conv_w = 4'(MIN_W); end
            CONV_SEC: begin conv_bin = 10'(snap_q[SEC_LSB +: SEC_W]); conv_w = 4'(SEC_W); end
            CONV_MS:  begin conv_bin = snap_q[MS_LSB +: MS_W];        conv_w = 4'(MS_W);  end
            default:  ;
        endcase
    end

    bin2bcd_serial u_bcd (
        .clk_1khz (clk_1khz),
        .reset_in (reset_in),
        .start    (start_q),
        .bin      (conv_bin),
        .width    (conv_w),
        .done     (conv_done),
        .bcd      (conv_bcd)
    );

    // Each field's result is picked up on the load cycle of the following field
    always_ff @(posedge clk_1khz or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            start_q   <= 1'b0;
            bcd_hr_q  <= '0;
            bcd_min_q <= '0;
            bcd_sec_q <= '0;
            disp_q    <= '0;
            upd_q     <= 1'b0;
        end else begin
            upd_q   <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!hold) begin
                        snap_q  <= sat;
                        start_q <= 1'b1;
                        state_q <= CONV_HR;
                    end
                end
                CONV_HR: begin
                    if (conv_done) begin
                        start_q <= 1'b1;
                        state_q <= CONV_MIN;
                    end
                end
                CONV_MIN: begin
                    if (start_q)
                        bcd_hr_q <= conv_bcd[7:0];
                    if (conv_done) begin
                        start_q <= 1'b1;
                        state_q <= CONV_SEC;
                    end
                end
                CONV_SEC: begin
                    if (start_q)
                        bcd_min_q <= conv_bcd[7:0];
                    if (conv_done) begin
                        start_q <= 1'b1;
                        state_q <= CONV_MS;
                    end
                end
                CONV_MS: begin
                    if (start_q)
                        bcd_sec_q <= conv_bcd[7:0];
                    if (conv_done)
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    disp_q  <= {bcd_hr_q, bcd_min_q, bcd_sec_q, conv_bcd[11:4]};
                    upd_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [3:0] div_q;
    logic [2:0] idx_q;
    logic [7:0] an_q;
    logic [6:0] seg_q;
    logic       dp_q;
    logic [3:0] nib;

    assign nib = disp_q[{idx_q, 2'b00} +: 4];

    always_ff @(posedge clk_1khz or negedge reset_in) begin
        if (!reset_in) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            if (div_q == 4'(SCAN_DIV - 1)) begin
                div_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                div_q <= div_q + 4'd1;
            end
            an_q  <= ~(8'd1 << idx_q);
            seg_q <= seg_encode(nib);
            dp_q  <= ~((idx_q == 3'd6) || (idx_q == 3'd4) || (idx_q == 3'd2) ||
                       ((idx_q == 3'd0) && hold));
        end
    end

    // Internal registers are active-low; flip once at the pins if required
    assign seg = SEG_ACTIVE_LOW ? seg_q : ~seg_q;
    assign dp  = SEG_ACTIVE_LOW ? dp_q  : ~dp_q;
    assign an  = SEG_ACTIVE_LOW ? an_q  : ~an_q;
    assign upd = upd_q;

endmodule
